usb_send_data: RTL and testbench
================================

USB_SEND_DATA -- requirements
Module: usb_send_data

Interface
REQ-001 The module SHALL have these ports:
- clk  in  1  rising-edge clock, one USB bit time per cycle.
- rst_L  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to send one packet; sampled only in IDLE.
- pid  in  4  packet ID nibble; transmitted byte = {~pid, pid}.
- has_data  in  1  1 = data packet (64-bit payload plus CRC16); 0 = handshake/token-style packet (no payload, no CRC).
- data  in  64  payload, captured at start acceptance.
- dp_out  out  1  D+ line drive.
- dm_out  out  1  D- line drive.
- bus_en  out  1  line driver enable.
- busy  out  1  high from acceptance until the end of EOP.
- done  out  1  single-cycle pulse in the final EOP cycle.

Function
REQ-002 The module SHALL implement the states IDLE, SYNC, PID, DATA, CRC and EOP.
REQ-003 In IDLE with start=1, the module SHALL latch pid, has_data and data, and move to SYNC; start SHALL be ignored in every other state.
REQ-004 All outputs SHALL be registered; the first SYNC line symbol SHALL appear the cycle after start is sampled.
REQ-005 SYNC SHALL send raw bits 0,0,0,0,0,0,0,1.
REQ-006 PID SHALL send {~pid,pid} LSB first; it SHALL then go to DATA if has_data=1, else to EOP.
REQ-007 DATA SHALL send data[0] through data[63] in order.
REQ-008 CRC SHALL send 16 bits: the complement of the CRC16, bit 15 first.
REQ-009 The CRC16 SHALL use polynomial 16'h8005, be initialised to 16'hFFFF on entry to DATA, and be updated on payload bits only, never on stuff bits.
REQ-010 Bit stuffing:
- Track consecutive raw 1s across SYNC, PID, DATA and CRC.
- After the sixth consecutive 1, insert one 0 and reset the count to 0.
- During the inserted bit, stall the FSM bit counter, the data shift and the CRC update (internal pause).
REQ-011 A stuff bit SHALL still be inserted if six consecutive 1s end on the last CRC bit, before EOP begins.
REQ-012 NRZI encoding SHALL apply to every non-EOP bit: raw 0 toggles the line state, raw 1 holds it.
REQ-013 Line-state encodings SHALL be:
- J = dp 1, dm 0.
- K = dp 0, dm 1.
- SE0 = dp 0, dm 0.
- Before SYNC, the line state SHALL be J.
REQ-014 EOP SHALL be exactly three cycles: SE0, SE0, J. done=1 in the J cycle, then the module SHALL return to IDLE.
REQ-015 bus_en SHALL be 1 from the first SYNC symbol through the EOP J cycle inclusive, and 0 otherwise.
REQ-016 In IDLE the outputs SHALL be: dp_out=1, dm_out=0, bus_en=0, busy=0, done=0.
REQ-017 Unstuffed packet length SHALL be 19 cycles when has_data=0 and 99 cycles when has_data=1; each stuff bit SHALL add one cycle.
REQ-018 start asserted in the done cycle SHALL be ignored; start in the following cycle SHALL be accepted.

Reset
REQ-019 On rst_L=0, at any time including mid-packet, the module SHALL enter IDLE with the following values:
- Outputs: dp_out=1, dm_out=0, bus_en=0, busy=0, done=0.
- Internal state: all counters 0, ones-count 0, CRC 16'hFFFF, latched data 0.
REQ-020 A packet interrupted by reset SHALL NOT be resumed, and no done pulse SHALL be generated for it.

Structure
REQ-021 The shared package usb_pkg SHALL hold:
- the state enum;
- the SYNC pattern 8'b1000_0000;
- CRC16 polynomial 16'h8005, initial value 16'hFFFF and residual 16'h800D;
- the J/K/SE0 {dp,dm} encodings.
REQ-022 Stuffing and NRZI encoding SHALL live in one sub-module, usb_stuff_nrzi:
- inputs: raw bit, valid, eop-select;
- outputs: dp, dm and pause back to the FSM.
REQ-023 The FSM, bit counters and CRC register SHALL reside in usb_send_data.

Verification
REQ-024 ACK: pid=4'h2, has_data=0 -> PID byte 8'hD2; SYNC line sequence K J K J K J K K; 19 busy cycles; exactly one done pulse.
REQ-025 DATA0 zeros: pid=4'h3, data=64'h0 -> byte 8'hC3; no stuff bits in DATA; a bench decoder running CRC16 over the data plus the received CRC ends at 16'h800D.
REQ-026 DATA1 ones: pid=4'hB, data=64'hFFFF_FFFF_FFFF_FFFF -> exactly 10 stuff zeros within DATA, each followed by a line toggle; the decoded payload equals the input.
REQ-027 The following start pulses SHALL all be ignored, and the next packet SHALL start only after busy falls:
- start pulses during SYNC, DATA and the done cycle;
- the data input changing mid-packet, which SHALL NOT alter the transmitted bits.
REQ-028 Reset at DATA bit 20 -> next cycle: dp=1, dm=0, bus_en=0, busy=0, no done; a subsequent start sends a complete packet, checked as in REQ-025.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB bit-level transmitter.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } state_e;

  // Packet header captured when a send request is accepted
  typedef struct packed {
    logic [3:0] pid;
    logic       has_data;
  } pkt_hdr_t;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned CRC_W     = 16;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned ONES_W    = 3;
  localparam int unsigned STUFF_RUN = 6;

  localparam logic [7:0]  SYNC_PATTERN   = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // {dp,dm} line-state encodings
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // One serial CRC16 step, payload bits fed LSB first
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
    crc16_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_stuff_nrzi.sv
// Bit stuffer and NRZI line encoder; stalls the sender while a stuff bit goes out.
module usb_stuff_nrzi
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic raw_bit,
  input  logic valid,
  input  logic eop_sel,
  output logic dp,
  output logic dm,
  output logic pause_c
);

  logic [ONES_W-1:0] ones_cnt, ones_nxt;
  logic              line_k, line_k_nxt;
  logic              eop_emit;
  logic [1:0]        line_nxt;

  // A full run of ones forces a stuff bit ahead of whatever is presented
  assign pause_c = valid && (ones_cnt == ONES_W'(STUFF_RUN));

  always_comb begin
    ones_nxt   = '0;
    line_k_nxt = 1'b0;
    eop_emit   = 1'b0;
    if (valid) begin
      if (pause_c) begin
        line_k_nxt = ~line_k;
      end else if (eop_sel) begin
        eop_emit = 1'b1;
      end else if (raw_bit) begin
        ones_nxt   = ones_cnt + ONES_W'(1);
        line_k_nxt = line_k;
      end else begin
        line_k_nxt = ~line_k;
      end
    end
    if (eop_emit) begin
      line_nxt = raw_bit ? LINE_J : LINE_SE0;
    end else begin
      line_nxt = line_k_nxt ? LINE_K : LINE_J;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      ones_cnt <= '0;
      line_k   <= 1'b0;
      dp       <= LINE_J[1];
      dm       <= LINE_J[0];
    end else begin
      ones_cnt <= ones_nxt;
      line_k   <= line_k_nxt;
      dp       <= line_nxt[1];
      dm       <= line_nxt[0];
    end
  end

endmodule

// File: rtl/usb_send_data.sv
// USB packet transmitter: SYNC, PID, optional 64-bit payload with CRC16, EOP.
module usb_send_data
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start,
  input  logic [3:0]        pid,
  input  logic              has_data,
  input  logic [DATA_W-1:0] data,
  output logic              dp_out,
  output logic              dm_out,
  output logic              bus_en,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pkt_hdr_t          hdr_q, hdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              bus_en_d, busy_d, done_d;
  logic              raw_bit_c, valid_c, eop_sel_c, pause_c;
  logic [7:0]        pid_byte;
  logic [3:0]        crc_idx;

  assign pid_byte = {~hdr_q.pid, hdr_q.pid};

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      crc_q   <= CRC16_INIT;
      bus_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      bus_en  <= bus_en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state and the raw bit presented to the line encoder this cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    crc_d     = crc_q;
    raw_bit_c = 1'b0;
    valid_c   = 1'b0;
    eop_sel_c = 1'b0;
    done_d    = 1'b0;
    crc_idx   = 4'(CRC_W - 1) - cnt_q[3:0];

    case (state_q)
      ST_IDLE: begin
        // First SYNC bit leaves on the accepting edge
        if (start) begin
          hdr_d.pid      = pid;
          hdr_d.has_data = has_data;
          data_d         = data;
          crc_d          = CRC16_INIT;
          valid_c        = 1'b1;
          raw_bit_c      = SYNC_PATTERN[0];
          state_d        = ST_SYNC;
          cnt_d          = CNT_W'(1);
        end
      end

      ST_SYNC: begin
        valid_c   = 1'b1;
        raw_bit_c = SYNC_PATTERN[cnt_q[2:0]];
        if (!pause_c) begin
          if (cnt_q == CNT_W'(7)) begin
            state_d = ST_PID;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PID: begin
        valid_c   = 1'b1;
        raw_bit_c = pid_byte[cnt_q[2:0]];
        if (!pause_c) begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (hdr_q.has_data) begin
              state_d = ST_DATA;
              crc_d   = CRC16_INIT;
            end else begin
              state_d = ST_EOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DATA: begin
        valid_c   = 1'b1;
        raw_bit_c = data_q[0];
        if (!pause_c) begin
          data_d = data_q >> 1;
          crc_d  = crc16_next(crc_q, data_q[0]);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CRC: begin
        valid_c   = 1'b1;
        raw_bit_c = ~crc_q[crc_idx];
        if (!pause_c) begin
          if (cnt_q == CNT_W'(CRC_W - 1)) begin
            state_d = ST_EOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EOP: begin
        // Counts 0..2 drive SE0, SE0, J; count 3 is the done cycle, start still ignored
        if (cnt_q < CNT_W'(3)) begin
          valid_c   = 1'b1;
          eop_sel_c = 1'b1;
          raw_bit_c = (cnt_q == CNT_W'(2));
          if (!pause_c) begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == CNT_W'(2));
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    bus_en_d = valid_c;
    busy_d   = valid_c;
  end

  usb_stuff_nrzi u_stuff_nrzi (
    .clk     (clk),
    .rst_L   (rst_L),
    .raw_bit (raw_bit_c),
    .valid   (valid_c),
    .eop_sel (eop_sel_c),
    .dp      (dp_out),
    .dm      (dm_out),
    .pause_c (pause_c)
  );

endmodule

// File: tb/tb_usb_send_data.sv
// Self-checking bench for usb_send_data: packet-level reference model plus line decoder.
module tb_usb_send_data;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        start;
  logic [3:0]  pid;
  logic        has_data;
  logic [63:0] data;
  logic        dp_out, dm_out, bus_en, busy, done;

  int checks = 0;
  int errors = 0;
  int busy_cnt, done_cnt;

  logic [4:0] exp_q[$];   // {dp,dm,bus_en,busy,done} per cycle
  logic [1:0] cap_q[$];   // captured {dp,dm}

  usb_send_data dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .start    (start),
    .pid      (pid),
    .has_data (has_data),
    .data     (data),
    .dp_out   (dp_out),
    .dm_out   (dm_out),
    .bus_en   (bus_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return fb ? ((c << 1) ^ 16'h8005) : (c << 1);
  endfunction

  // Expected line symbols from the packet's raw bit list, then stuffing and NRZI
  task automatic build_expect(input logic [3:0] p, input logic hd, input logic [63:0] d);
    logic        raw[$];
    logic [7:0]  pb;
    logic [15:0] c;
    logic        lvl;
    int          ones;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    pb = {~p, p};
    for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
    if (hd) begin
      c = 16'hFFFF;
      for (int i = 0; i < 64; i++) begin
        raw.push_back(d[i]);
        c = crc_bit(c, d[i]);
      end
      for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
    end
    exp_q = {};
    lvl   = 1'b1;
    ones  = 0;
    for (int i = 0; i < raw.size(); i++) begin
      if (!raw[i]) lvl = ~lvl;
      ones = raw[i] ? ones + 1 : 0;
      exp_q.push_back({lvl, ~lvl, 3'b110});
      if (ones == 6) begin
        lvl  = ~lvl;
        ones = 0;
        exp_q.push_back({lvl, ~lvl, 3'b110});
      end
    end
    exp_q.push_back(5'b00_110);
    exp_q.push_back(5'b00_110);
    exp_q.push_back(5'b10_111);
  endtask

  task automatic run_packet(input logic [3:0] p, input logic hd, input logic [63:0] d,
                            input bit disturb, input bit no_wait);
    build_expect(p, hd, d);
    cap_q    = {};
    busy_cnt = 0;
    done_cnt = 0;
    if (!no_wait) @(negedge clk);
    pid = p; has_data = hd; data = d; start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("sym%0d", k), 64'({dp_out, dm_out, bus_en, busy, done}), 64'(exp_q[k]));
      cap_q.push_back({dp_out, dm_out});
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (disturb) begin
        if (k == 3 || k == 40 || k == exp_q.size() - 1) start = 1'b1;
        if (k == 20) begin
          data     = {$urandom, $urandom};
          pid      = 4'($urandom);
          has_data = ~hd;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", 64'({dp_out, dm_out, bus_en, busy, done}), 64'(5'b10_000));
  endtask

  // NRZI-decode and destuff the captured line up to the first SE0
  task automatic decode(output logic [7:0] pidb, output logic [63:0] pay, output logic [15:0] res,
                        output int st_data, output int st_all, output int st_bad);
    logic       r[$];
    logic [1:0] lvl;
    logic       b;
    int         ones;
    lvl = 2'b10; ones = 0; st_data = 0; st_all = 0; st_bad = 0;
    pidb = '0; pay = '0; res = 16'hFFFF;
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i] == 2'b00) break;
      b   = (cap_q[i] == lvl);
      lvl = cap_q[i];
      if (ones == 6) begin
        st_all++;
        if (b) st_bad++;
        if (r.size() >= 17 && r.size() <= 80) st_data++;
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        r.push_back(b);
      end
    end
    if (r.size() >= 16) for (int i = 0; i < 8; i++) pidb[i] = r[8 + i];
    if (r.size() >= 96) begin
      for (int i = 0; i < 64; i++) pay[i] = r[16 + i];
      for (int i = 16; i < 96; i++) res = crc_bit(res, r[i]);
    end
  endtask

  task automatic check_data_pkt(input string tag, input logic [7:0] pid_exp, input logic [63:0] d,
                                output int st_data);
    logic [7:0]  pidb;
    logic [63:0] pay;
    logic [15:0] res;
    int          st_all, st_bad;
    decode(pidb, pay, res, st_data, st_all, st_bad);
    chk({tag, "_pid"}, 64'(pidb), 64'(pid_exp));
    chk({tag, "_payload"}, pay, d);
    chk({tag, "_residual"}, 64'(res), 64'(16'h800D));
    chk({tag, "_stuff_toggle"}, 64'(st_bad), 64'(0));
    chk({tag, "_len"}, 64'(busy_cnt), 64'(99 + st_all));
    chk({tag, "_done"}, 64'(done_cnt), 64'(1));
  endtask

  initial begin
    logic [7:0]  pidb;
    logic [63:0] pay, d;
    logic [15:0] res, sync_sym;
    logic [3:0]  p;
    logic        hd;
    int          st_data, st_all, st_bad;

    rst_L = 1'b0; start = 1'b0; pid = '0; has_data = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset", 64'({dp_out, dm_out, bus_en, busy, done}), 64'(5'b10_000));
    rst_L = 1'b1;
    @(negedge clk);
    chk("idle", 64'({dp_out, dm_out, bus_en, busy, done}), 64'(5'b10_000));

    // ACK handshake
    run_packet(4'h2, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    decode(pidb, pay, res, st_data, st_all, st_bad);
    chk("ack_pid", 64'(pidb), 64'(8'hD2));
    sync_sym = {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5], cap_q[6], cap_q[7]};
    chk("ack_sync", 64'(sync_sym), 64'(16'h6665));
    chk("ack_busy", 64'(busy_cnt), 64'(19));
    chk("ack_done", 64'(done_cnt), 64'(1));

    // DATA0 zeros
    run_packet(4'h3, 1'b1, 64'h0, 1'b0, 1'b0);
    check_data_pkt("zeros", 8'hC3, 64'h0, st_data);
    chk("zeros_stuff", 64'(st_data), 64'(0));

    // DATA1 ones, sent back-to-back in the cycle after done
    run_packet(4'hB, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    check_data_pkt("ones", 8'h4B, 64'hFFFF_FFFF_FFFF_FFFF, st_data);
    chk("ones_stuff", 64'(st_data), 64'(10));

    // Stray start pulses and input changes mid-packet
    d = {$urandom, $urandom};
    p = 4'($urandom);
    run_packet(p, 1'b1, d, 1'b1, 1'b0);
    check_data_pkt("disturb", {~p, p}, d, st_data);

    // Random packets
    for (int n = 0; n < 6; n++) begin
      p  = 4'($urandom);
      hd = 1'($urandom);
      d  = {$urandom, $urandom};
      run_packet(p, hd, d, 1'b0, n[0]);
      if (hd) begin
        check_data_pkt($sformatf("rnd%0d", n), {~p, p}, d, st_data);
      end else begin
        decode(pidb, pay, res, st_data, st_all, st_bad);
        chk($sformatf("rnd%0d_pid", n), 64'(pidb), 64'({~p, p}));
        chk($sformatf("rnd%0d_len", n), 64'(busy_cnt), 64'(19 + st_all));
      end
    end

    // Reset while DATA bit 20 is on the line
    @(negedge clk);
    pid = 4'h3; has_data = 1'b1; data = 64'h0; start = 1'b1;
    repeat (37) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", 64'(busy), 64'(1));
    rst_L = 1'b0;
    @(negedge clk);
    chk("mid_reset", 64'({dp_out, dm_out, bus_en, busy, done}), 64'(5'b10_000));
    rst_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), 64'({dp_out, dm_out, bus_en, busy, done}), 64'(5'b10_000));
    end
    run_packet(4'h3, 1'b1, 64'h0, 1'b0, 1'b0);
    check_data_pkt("after_reset", 8'hC3, 64'h0, st_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
